pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It generates the write-enables, bubble and flush controls for the PC, IF/ID, ID/EX and EX/MEM latches. It detects load-use hazards against the instruction in EX, freezes the pipe while data memory is busy, squashes wrong-path instructions on a taken branch or jump, and drains the pipe on HALT. It sits beside the decode stage and drives the ID/EX latch `stall` and `en` inputs directly.

## Interface
- `NOP_INSTR`, 16'h0800: encoding the ID/EX latch writes when `id_ex_bubble`=1 (informational; exported for the latch).
- `MAX_MEM_WAIT`, 15: consecutive busy cycles before a memory timeout is declared; range 1..255.
- `DRAIN_CYCLES`, 3: bubble cycles issued after HALT before `halted` asserts.
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` in 3 each: source register fields of the instruction in ID.
- `id_reading_rs`, `id_reading_rt` in 1 each: ID instruction actually reads Rs / Rt.
- `ex_dst_reg` in 3: destination register of the instruction in EX.
- `ex_reg_write`, `ex_mem_to_reg` in 1 each: EX instruction writes the register file, and is a load.
- `branch_taken` in 1: branch or jump resolved taken in EX this cycle.
- `mem_busy` in 1: data memory cannot complete this cycle.
- `halt_id` in 1: HALT decoded in ID.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` out 1 each: latch write-enables.
- `id_ex_bubble` out 1: ID/EX captures NOP and zeroed control signals.
- `if_id_flush` out 1: IF/ID captures NOP.
- `halted` out 1: sticky; the pipe is drained and stopped.
- `mem_timeout_err` out 1: sticky; memory busy exceeded `MAX_MEM_WAIT`.
- `state` out 3: current FSM state, for debug.

## Operation
- FSM states: RUN=0, MEM_WAIT=1, DRAIN=2, HALTED=3, ERROR=4. Outputs are Mealy, derived from state and inputs.
- Defaults: every enable=1, `id_ex_bubble`=0, `if_id_flush`=0.
- Load-use hazard `lu` = `ex_reg_write` & `ex_mem_to_reg` & ((`id_reading_rs` & `id_rs`==`ex_dst_reg`) | (`id_reading_rt` & `id_rt`==`ex_dst_reg`)).
- RUN, priority from highest:
  - `mem_busy`: all four enables=0. Save `ret_state`=RUN, set `wait_cnt`=1, go to MEM_WAIT.
  - `branch_taken`: `pc_en`=1 (loads the target), `if_id_flush`=1, `id_ex_bubble`=1. Stay in RUN.
  - `lu`: `pc_en`=0, `if_id_en`=0, `id_ex_bubble`=1. Exactly one bubble is inserted per hazard.
  - `halt_id`: `pc_en`=0, `if_id_en`=0. HALT itself enters ID/EX. Set `drain_cnt`=0, go to DRAIN.
- MEM_WAIT:
  - While `mem_busy`=1: all enables=0, and `wait_cnt` increments.
  - When `wait_cnt`==`MAX_MEM_WAIT` with `mem_busy` still 1: go to ERROR.
  - When `mem_busy`=0: apply the `ret_state` default outputs this cycle, then return to `ret_state`. `wait_cnt` clears.
- DRAIN:
  - Outputs: `pc_en`=0, `if_id_en`=0, `id_ex_bubble`=1, `id_ex_en`=1, `ex_mem_en`=1. `drain_cnt` increments.
  - At `drain_cnt`==`DRAIN_CYCLES`-1: go to HALTED.
  - `branch_taken` (an older branch): flush as in RUN, cancel the halt, go to RUN.
  - `mem_busy`: freeze, save `ret_state`=DRAIN, go to MEM_WAIT. `drain_cnt` holds.
- HALTED and ERROR: all enables=0. `halted`=1 in HALTED; `mem_timeout_err`=1 in ERROR. Both states exit only on reset.
- Counters saturate and never wrap. `wait_cnt` is 8 bits; `drain_cnt` is 2 bits minimum.

## Timing
- Reset asserted (any time, asynchronous): state=RUN, `ret_state`=RUN, counters=0, `halted`=0, `mem_timeout_err`=0.
  - Combinational outputs are forced to all enables=0, `id_ex_bubble`=0, `if_id_flush`=0 while `rst`=0.
  - The first active edge after deassertion runs in RUN.
- Hazard, flush and freeze responses are zero-latency: they take effect at the same edge as the triggering input.
- State changes take effect one edge later.
- A load-use stall costs 1 cycle. A taken branch costs 2 squashed slots. A memory stall costs N busy cycles plus 0 extra.
- Simultaneous events resolve by the priority list: memory freeze beats branch, branch beats load-use, load-use beats halt.
- A HALT whose bubble-check collides with `lu` waits for the hazard to clear.

## Structure
- Package `pipe_ctrl_pkg` holds the state encoding constants, `NOP_INSTR`, and the default `MAX_MEM_WAIT`/`DRAIN_CYCLES`.
- Sub-module `load_use_detect` is purely combinational and computes `lu`.
- The FSM, counters and output decode live in the top module.

## Test plan
- Load R1, then `add R2,R1,R3` with EX `ex_dst_reg`=1, `id_rs`=1 -> one cycle of `pc_en`=0, `if_id_en`=0, `id_ex_bubble`=1, then normal flow. With `id_reading_rs`=0 -> no stall.
- `branch_taken`=1 in RUN -> `if_id_flush`=1, `id_ex_bubble`=1, `pc_en`=1 for exactly one cycle.
- Same cycle, `branch_taken`=1 and `lu`=1 -> flush only, no stall.
- `mem_busy` high 4 cycles -> enables 0 for 4 cycles, state=1, then RUN. With `mem_busy` high 15 cycles (`MAX_MEM_WAIT`=15) -> state=4, `mem_timeout_err`=1, held until reset.
- `halt_id`=1 -> 3 DRAIN cycles with `id_ex_bubble`=1, then `halted`=1, state=3. Add `mem_busy` for 2 cycles during drain -> drain completes 2 cycles later.
- `rst`=0 mid-MEM_WAIT -> immediate state=0, outputs forced 0. After release, enables=1 on the next cycle.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the 5-stage pipeline sequencing controller:
// FSM encodings, the NOP the ID/EX latch inserts, and default timing limits.
package pipe_ctrl_pkg;

   localparam logic [2:0] ST_RUN      = 3'd0;
   localparam logic [2:0] ST_MEM_WAIT = 3'd1;
   localparam logic [2:0] ST_DRAIN    = 3'd2;
   localparam logic [2:0] ST_HALTED   = 3'd3;
   localparam logic [2:0] ST_ERROR    = 3'd4;

   localparam logic [15:0] NOP_INSTR = 16'h0800;

   localparam int unsigned MAX_MEM_WAIT_DEF = 15;
   localparam int unsigned DRAIN_CYCLES_DEF = 3;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic id_ex_bubble;
      logic if_id_flush;
   } ctrl_t;

   // All four latch enables set to 'en', with no bubble and no flush.
   function automatic ctrl_t ctrl_all(input logic en);
      ctrl_t c;
      c.pc_en        = en;
      c.if_id_en     = en;
      c.id_ex_en     = en;
      c.ex_mem_en    = en;
      c.id_ex_bubble = 1'b0;
      c.if_id_flush  = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check: the load in EX writes a register
// that the instruction in ID actually reads.
module load_use_detect (
   input  logic [2:0] id_rs,
   input  logic [2:0] id_rt,
   input  logic       id_reading_rs,
   input  logic       id_reading_rt,
   input  logic [2:0] ex_dst_reg,
   input  logic       ex_reg_write,
   input  logic       ex_mem_to_reg,
   output logic       lu
);

   assign lu = ex_reg_write & ex_mem_to_reg &
               ((id_reading_rs & (id_rs == ex_dst_reg)) |
                (id_reading_rt & (id_rt == ex_dst_reg)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: latch enables, bubbles and flushes for
// load-use stalls, memory freezes, taken branches and HALT draining.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MAX_MEM_WAIT = MAX_MEM_WAIT_DEF,
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] id_rs,
   input  logic [2:0] id_rt,
   input  logic       id_reading_rs,
   input  logic       id_reading_rt,
   input  logic [2:0] ex_dst_reg,
   input  logic       ex_reg_write,
   input  logic       ex_mem_to_reg,
   input  logic       branch_taken,
   input  logic       mem_busy,
   input  logic       halt_id,
   output logic       pc_en,
   output logic       if_id_en,
   output logic       id_ex_en,
   output logic       ex_mem_en,
   output logic       id_ex_bubble,
   output logic       if_id_flush,
   output logic       halted,
   output logic       mem_timeout_err,
   output logic [2:0] state
);

   localparam int DRAIN_W = (DRAIN_CYCLES < 4) ? 2 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
   localparam logic [7:0]         MAX_WAIT   = 8'(MAX_MEM_WAIT);

   logic [2:0]         state_nxt;
   logic [2:0]         ret_state;
   logic [2:0]         ret_nxt;
   logic [7:0]         wait_cnt;
   logic [7:0]         wait_nxt;
   logic [7:0]         wait_inc;
   logic [DRAIN_W-1:0] drain_cnt;
   logic [DRAIN_W-1:0] drain_nxt;
   logic [DRAIN_W-1:0] drain_inc;
   logic               lu;
   ctrl_t              ctrl;
   ctrl_t              ctrl_drain;
   ctrl_t              ctrl_flush;

   load_use_detect u_lu (
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_reading_rs (id_reading_rs),
      .id_reading_rt (id_reading_rt),
      .ex_dst_reg    (ex_dst_reg),
      .ex_reg_write  (ex_reg_write),
      .ex_mem_to_reg (ex_mem_to_reg),
      .lu            (lu)
   );

   assign wait_inc  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
   assign drain_inc = (drain_cnt == '1) ? drain_cnt : drain_cnt + DRAIN_ONE;

   always_comb begin
      ctrl_drain              = ctrl_all(1'b1);
      ctrl_drain.pc_en        = 1'b0;
      ctrl_drain.if_id_en     = 1'b0;
      ctrl_drain.id_ex_bubble = 1'b1;
      ctrl_flush              = ctrl_all(1'b1);
      ctrl_flush.if_id_flush  = 1'b1;
      ctrl_flush.id_ex_bubble = 1'b1;
   end

   // Mealy decode: freeze beats branch, branch beats load-use, load-use beats halt.
   always_comb begin
      ctrl      = ctrl_all(1'b1);
      state_nxt = state;
      ret_nxt   = ret_state;
      wait_nxt  = wait_cnt;
      drain_nxt = drain_cnt;
      case (state)
         ST_RUN: begin
            if (mem_busy) begin
               ctrl      = ctrl_all(1'b0);
               ret_nxt   = ST_RUN;
               wait_nxt  = 8'd1;
               state_nxt = ST_MEM_WAIT;
            end else if (branch_taken) begin
               ctrl = ctrl_flush;
            end else if (lu) begin
               ctrl.pc_en        = 1'b0;
               ctrl.if_id_en     = 1'b0;
               ctrl.id_ex_bubble = 1'b1;
            end else if (halt_id) begin
               ctrl.pc_en    = 1'b0;
               ctrl.if_id_en = 1'b0;
               drain_nxt     = '0;
               state_nxt     = ST_DRAIN;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_busy) begin
               // wait_inc counts this busy cycle, so MAX_MEM_WAIT busy cycles in total trip the timeout
               ctrl     = ctrl_all(1'b0);
               wait_nxt = wait_inc;
               if (wait_inc >= MAX_WAIT) begin
                  state_nxt = ST_ERROR;
               end
            end else begin
               wait_nxt = 8'd0;
               if (ret_state == ST_DRAIN) begin
                  // The release cycle is itself a drain slot, so the freeze costs no extra cycle
                  ctrl      = ctrl_drain;
                  drain_nxt = drain_inc;
                  state_nxt = (drain_cnt == DRAIN_LAST) ? ST_HALTED : ST_DRAIN;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_DRAIN: begin
            if (mem_busy) begin
               ctrl      = ctrl_all(1'b0);
               ret_nxt   = ST_DRAIN;
               wait_nxt  = 8'd1;
               state_nxt = ST_MEM_WAIT;
            end else if (branch_taken) begin
               ctrl      = ctrl_flush;
               drain_nxt = '0;
               state_nxt = ST_RUN;
            end else begin
               ctrl      = ctrl_drain;
               drain_nxt = drain_inc;
               state_nxt = (drain_cnt == DRAIN_LAST) ? ST_HALTED : ST_DRAIN;
            end
         end
         ST_HALTED: begin
            ctrl = ctrl_all(1'b0);
         end
         default: begin
            ctrl      = ctrl_all(1'b0);
            state_nxt = ST_ERROR;
         end
      endcase
      if (!rst) begin
         ctrl = ctrl_all(1'b0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_RUN;
         ret_state <= ST_RUN;
         wait_cnt  <= 8'd0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nxt;
         ret_state <= ret_nxt;
         wait_cnt  <= wait_nxt;
         drain_cnt <= drain_nxt;
      end
   end

   assign pc_en           = ctrl.pc_en;
   assign if_id_en        = ctrl.if_id_en;
   assign id_ex_en        = ctrl.id_ex_en;
   assign ex_mem_en       = ctrl.ex_mem_en;
   assign id_ex_bubble    = ctrl.id_ex_bubble;
   assign if_id_flush     = ctrl.if_id_flush;
   assign halted          = (state == ST_HALTED);
   assign mem_timeout_err = (state == ST_ERROR);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-computed per-cycle controls,
// state and sticky flags for stalls, flushes, freezes, drain and reset.
module tb_pipe_hazard_ctrl;

   // Control vector order: pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, if_id_flush
   localparam logic [5:0] EN_ALL = 6'b111100;
   localparam logic [5:0] FREEZE = 6'b000000;
   localparam logic [5:0] STALL  = 6'b001110;
   localparam logic [5:0] FLUSH  = 6'b111111;
   localparam logic [5:0] HALT_I = 6'b001100;
   localparam logic [5:0] DRAIN  = 6'b001110;

   logic       clk;
   logic       rst;
   logic [2:0] id_rs;
   logic [2:0] id_rt;
   logic       id_reading_rs;
   logic       id_reading_rt;
   logic [2:0] ex_dst_reg;
   logic       ex_reg_write;
   logic       ex_mem_to_reg;
   logic       branch_taken;
   logic       mem_busy;
   logic       halt_id;
   logic       pc_en;
   logic       if_id_en;
   logic       id_ex_en;
   logic       ex_mem_en;
   logic       id_ex_bubble;
   logic       if_id_flush;
   logic       halted;
   logic       mem_timeout_err;
   logic [2:0] state;
   logic [10:0] obs;

   int vectors     = 0;
   int miscompares = 0;

   pipe_hazard_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_reading_rs   (id_reading_rs),
      .id_reading_rt   (id_reading_rt),
      .ex_dst_reg      (ex_dst_reg),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_to_reg   (ex_mem_to_reg),
      .branch_taken    (branch_taken),
      .mem_busy        (mem_busy),
      .halt_id         (halt_id),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .id_ex_en        (id_ex_en),
      .ex_mem_en       (ex_mem_en),
      .id_ex_bubble    (id_ex_bubble),
      .if_id_flush     (if_id_flush),
      .halted          (halted),
      .mem_timeout_err (mem_timeout_err),
      .state           (state)
   );

   assign obs = {halted, mem_timeout_err, state,
                 pc_en, if_id_en, id_ex_en, ex_mem_en, id_ex_bubble, if_id_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [10:0] observed,
                              input logic [10:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %b, expected %b (halted,err,state[3],pc,ifid,idex,exmem,bubble,flush)",
                  tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] rs, input logic [2:0] rt,
                                input logic rd_rs, input logic rd_rt,
                                input logic [2:0] dst, input logic rw, input logic m2r,
                                input logic br, input logic busy, input logic halt);
      id_rs         = rs;
      id_rt         = rt;
      id_reading_rs = rd_rs;
      id_reading_rt = rd_rt;
      ex_dst_reg    = dst;
      ex_reg_write  = rw;
      ex_mem_to_reg = m2r;
      branch_taken  = br;
      mem_busy      = busy;
      halt_id       = halt;
   endtask

   task automatic applyIdle();
      applyStimulus(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Inputs are already set just after a rising edge; check mid-cycle, then advance.
   task automatic runCycle(input string tag, input logic [5:0] ctl, input logic [2:0] st,
                           input logic hl, input logic er);
      @(negedge clk);
      checkOutput(tag, obs, {hl, er, st, ctl});
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input string tag);
      rst = 1'b0;
      applyIdle();
      #1;
      checkOutput(tag, obs, {1'b0, 1'b0, 3'd0, FREEZE});
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      applyIdle();
      #2;
      checkOutput("reset_initial", obs, {1'b0, 1'b0, 3'd0, FREEZE});
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Load-use detection and its qualifiers
      applyIdle();                                                   runCycle("idle", EN_ALL, 3'd0, 0, 0);
      applyStimulus(3'd1, 3'd2, 1, 1, 3'd1, 1, 1, 0, 0, 0);          runCycle("lu_rs", STALL, 3'd0, 0, 0);
      applyStimulus(3'd1, 3'd2, 1, 1, 3'd1, 0, 0, 0, 0, 0);          runCycle("lu_bubble_in_ex", EN_ALL, 3'd0, 0, 0);
      applyStimulus(3'd1, 3'd2, 0, 0, 3'd1, 1, 1, 0, 0, 0);          runCycle("lu_rs_unread", EN_ALL, 3'd0, 0, 0);
      applyStimulus(3'd4, 3'd5, 1, 1, 3'd5, 1, 1, 0, 0, 0);          runCycle("lu_rt", STALL, 3'd0, 0, 0);
      applyStimulus(3'd4, 3'd5, 1, 0, 3'd5, 1, 1, 0, 0, 0);          runCycle("lu_rt_unread", EN_ALL, 3'd0, 0, 0);
      applyStimulus(3'd4, 3'd5, 1, 1, 3'd5, 1, 0, 0, 0, 0);          runCycle("alu_not_load", EN_ALL, 3'd0, 0, 0);
      applyStimulus(3'd4, 3'd5, 1, 1, 3'd6, 1, 1, 0, 0, 0);          runCycle("lu_other_reg", EN_ALL, 3'd0, 0, 0);

      // Branch flush, and branch over load-use
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 0, 0);          runCycle("branch", FLUSH, 3'd0, 0, 0);
      applyIdle();                                                   runCycle("branch_done", EN_ALL, 3'd0, 0, 0);
      applyStimulus(3'd1, 3'd2, 1, 1, 3'd1, 1, 1, 1, 0, 0);          runCycle("branch_over_lu", FLUSH, 3'd0, 0, 0);

      // Four busy cycles, the first colliding with a branch
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 1, 0);          runCycle("busy_over_branch", FREEZE, 3'd0, 0, 0);
      for (int i = 2; i <= 4; i++) begin
         applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0);
         runCycle($sformatf("busy%0d", i), FREEZE, 3'd1, 0, 0);
      end
      applyIdle();                                                   runCycle("busy_release", EN_ALL, 3'd1, 0, 0);
      applyIdle();                                                   runCycle("busy_back_run", EN_ALL, 3'd0, 0, 0);

      // HALT behind a load-use hazard, then the plain drain
      applyStimulus(3'd1, 3'd2, 1, 1, 3'd1, 1, 1, 0, 0, 1);          runCycle("halt_vs_lu", STALL, 3'd0, 0, 0);
      applyStimulus(3'd1, 3'd2, 1, 1, 3'd1, 0, 0, 0, 0, 1);          runCycle("halt_issue", HALT_I, 3'd0, 0, 0);
      applyIdle();                                                   runCycle("drain0", DRAIN, 3'd2, 0, 0);
      applyIdle();                                                   runCycle("drain1", DRAIN, 3'd2, 0, 0);
      applyIdle();                                                   runCycle("drain2", DRAIN, 3'd2, 0, 0);
      applyIdle();                                                   runCycle("halted", FREEZE, 3'd3, 1, 0);
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 1, 0);          runCycle("halted_sticky", FREEZE, 3'd3, 1, 0);
      doReset("reset_from_halted");

      // Two busy cycles in the middle of the drain
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 1);          runCycle("hb_issue", HALT_I, 3'd0, 0, 0);
      applyIdle();                                                   runCycle("hb_drain0", DRAIN, 3'd2, 0, 0);
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0);          runCycle("hb_busy1", FREEZE, 3'd2, 0, 0);
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0);          runCycle("hb_busy2", FREEZE, 3'd1, 0, 0);
      applyIdle();                                                   runCycle("hb_release", DRAIN, 3'd1, 0, 0);
      applyIdle();                                                   runCycle("hb_drain_last", DRAIN, 3'd2, 0, 0);
      applyIdle();                                                   runCycle("hb_halted", FREEZE, 3'd3, 1, 0);
      doReset("reset_after_hb");

      // An older branch resolving during drain cancels the halt
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 0, 1);          runCycle("db_issue", HALT_I, 3'd0, 0, 0);
      applyIdle();                                                   runCycle("db_drain0", DRAIN, 3'd2, 0, 0);
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 1, 0, 0);          runCycle("db_branch", FLUSH, 3'd2, 0, 0);
      applyIdle();                                                   runCycle("db_back_run", EN_ALL, 3'd0, 0, 0);

      // Fifteen busy cycles trip the timeout; the error is sticky
      for (int i = 1; i <= 15; i++) begin
         applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0);
         runCycle($sformatf("timeout_busy%0d", i), FREEZE, (i == 1) ? 3'd0 : 3'd1, 0, 0);
      end
      applyIdle();                                                   runCycle("timeout_err", FREEZE, 3'd4, 0, 1);
      applyIdle();                                                   runCycle("timeout_sticky", FREEZE, 3'd4, 0, 1);
      doReset("reset_from_error");

      // Asynchronous reset in the middle of a memory wait
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0);          runCycle("ar_busy1", FREEZE, 3'd0, 0, 0);
      applyStimulus(3'd0, 3'd0, 0, 0, 3'd0, 0, 0, 0, 1, 0);          runCycle("ar_busy2", FREEZE, 3'd1, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("async_reset", obs, {1'b0, 1'b0, 3'd0, FREEZE});
      @(negedge clk);
      rst = 1'b1;
      applyIdle();
      #1;
      checkOutput("reset_release", obs, {1'b0, 1'b0, 3'd0, EN_ALL});
      @(posedge clk);
      #1;
      applyIdle();                                                   runCycle("post_reset", EN_ALL, 3'd0, 0, 0);
      applyStimulus(3'd3, 3'd0, 1, 0, 3'd3, 1, 1, 0, 0, 0);          runCycle("post_reset_lu", STALL, 3'd0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
